csa_resolve_seq: RTL and testbench

- Consumer end of the carry-save reduction chain: accepts the redundant sum/carry vector pair produced by the last CSA stage of the multiplier tree.
- Resolves the pair into a binary result with a multi-cycle, chunked carry-propagate adder, using valid/ready handshakes on both sides.
- Sits between the final CSA stage and the product register; it trades latency for a short carry chain.

---
 rtl/csa_resolve_seq_if.sv | 13 +
 rtl/csa_resolve_seq.sv | 87 ++++++++
 tb/tb_csa_resolve_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/csa_resolve_seq_if.sv
// csa_resolve_seq_if: sum/carry in, resolved product out, valid/ready both ways
interface csa_resolve_seq_if #(parameter int W = 11);
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         in_valid;
  logic         in_ready;
  logic [W+1:0] result;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  modport slave (input sum, carry, in_valid, out_ready, output in_ready, result, out_valid, busy);
  modport master (output sum, carry, in_valid, out_ready, input in_ready, result, out_valid, busy);
endinterface

// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: resolves a carry-save sum/carry pair into binary, CHUNK bits per cycle
module csa_resolve_seq #(
  parameter int W     = 11,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             rst_n,
  csa_resolve_seq_if.slave bus
);
  localparam int WA  = W + 1;
  localparam int NCH = (WA + CHUNK - 1) / CHUNK;
  localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
  localparam int OW  = $clog2(WA + CHUNK) + 1;
  // live operand bits in the last chunk; ext[LB] is the carry out of bit W
  localparam int LB  = WA - (NCH - 1) * CHUNK;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state_q, state_d;
  logic [W:0]      a_q, a_d, b_q, b_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W+1:0]    res_q, res_d;
  logic [OW-1:0]   off;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]  ext;
  logic [W:0]      wmask, wdata;
  logic            last;
  assign off   = OW'(cnt_q) * OW'(CHUNK);
  assign a_ch  = CHUNK'(a_q >> off);
  assign b_ch  = CHUNK'(b_q >> off);
  assign ext   = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK + 1)'(c_q);
  assign last  = cnt_q == CW'(NCH - 1);
  assign wmask = (W + 1)'({CHUNK{1'b1}}) << off;
  assign wdata = (W + 1)'(ext[CHUNK-1:0]) << off;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = {1'b0, bus.sum};
        b_d     = {bus.carry, 1'b0};
        c_d     = 1'b0;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        res_d = (res_q & ~{1'b0, wmask}) | {1'b0, wdata};
        c_d   = ext[CHUNK];
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          res_d[W+1] = ext[LB];
          state_d    = DONE;
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.busy      = state_q == BUSY;
  assign bus.out_valid = state_q == DONE;
  assign bus.result    = res_q;
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.result));
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot({bus.in_ready, bus.busy, bus.out_valid}));
endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb_csa_resolve_seq: scoreboard bench, directed vectors at CHUNK=4 plus stalled random runs at CHUNK 1/3/4/12
module tb_csa_resolve_seq;
  localparam int W  = 11;
  localparam int NR = 250;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic rand_go = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [W+1:0] res;
    int           acc;
  } exp_t;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction
  function automatic void flag(string name, string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endfunction
  csa_resolve_seq_if #(.W(W)) bus ();
  csa_resolve_seq #(.W(W), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  exp_t e;
  logic ov_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) ov_seen = 1'b0;
    else begin
      if (bus.out_valid && !ov_seen && q.size() > 0) chk("latency_c4", cyc - q[0].acc, 3);
      ov_seen = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) flag("spurious_c4", "got an output handshake, required none pending");
        else begin
          e = q.pop_front();
          chk("result_c4", bus.result, e.res);
        end
      end
    end
  end
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W+1:0] r);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.sum = s;
    bus.carry = c;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (ok) q.push_back('{r, cyc + 1});
    else flag("accept_c4", "got in_ready low for 50 cycles, required acceptance");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = q.size() == 0 && bus.in_ready;
    end
    if (!ok) flag("drain_c4", "got no completion in 100 cycles, required drained scoreboard");
  endtask
  logic [W-1:0] vs[6] = '{11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h001, 11'h555};
  logic [W-1:0] vc[6] = '{11'h7FF, 11'h000, 11'h000, 11'h7FF, 11'h7FF, 11'h2AA};
  logic [W+1:0] ve[6] = '{13'h17FD, 13'h0000, 13'h07FF, 13'h0FFE, 13'h0FFF, 13'h0AA9};
  for (genvar g = 0; g < 4; g++) begin : rg
    localparam int CH = g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 12;
    localparam int NL = (W + 1 + CH - 1) / CH;
    csa_resolve_seq_if #(.W(W)) b ();
    csa_resolve_seq #(.W(W), .CHUNK(CH)) u (.clk(clk), .rst_n(rst_n), .bus(b));
    exp_t sq[$];
    exp_t se;
    logic seen = 1'b0;
    logic fin = 1'b0;
    always @(negedge clk) begin
      if (!rst_n) seen = 1'b0;
      else begin
        if (b.out_valid && !seen && sq.size() > 0) chk($sformatf("latency_c%0d", CH), cyc - sq[0].acc, NL);
        seen = b.out_valid;
        if (b.out_valid && b.out_ready) begin
          if (sq.size() == 0) flag($sformatf("spurious_c%0d", CH), "got an output handshake, required none pending");
          else begin
            se = sq.pop_front();
            chk($sformatf("result_c%0d", CH), b.result, se.res);
          end
        end
      end
    end
    initial begin : drv
      logic [W-1:0] s, c;
      logic ok;
      b.sum = '0;
      b.carry = '0;
      b.in_valid = 1'b0;
      b.out_ready = 1'b1;
      wait (rand_go);
      for (int n = 0; n < NR; n++) begin
        s = n == 0 ? '1 : W'($urandom);
        c = n == 0 ? '1 : W'($urandom);
        @(posedge clk); #1;
        b.sum = s;
        b.carry = c;
        b.in_valid = 1'b1;
        b.out_ready = 1'($urandom_range(0, 1));
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
          @(negedge clk);
          ok = b.in_ready;
          if (!ok) begin
            @(posedge clk); #1;
            b.out_ready = 1'($urandom_range(0, 1));
          end
        end
        if (ok) sq.push_back('{(W + 2)'(s) + ((W + 2)'(c) << 1), cyc + 1});
        else flag($sformatf("accept_c%0d", CH), "got in_ready low for 300 cycles, required acceptance");
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        b.out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      b.out_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        ok = sq.size() == 0 && b.in_ready;
      end
      if (!ok) flag($sformatf("drain_c%0d", CH), "got no completion in 100 cycles, required drained scoreboard");
      fin = 1'b1;
    end
  end
  initial begin
    logic ok;
    bus.sum = '0;
    bus.carry = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // basic pair: three busy cycles, then one output handshake
    send(11'h155, 11'h0AA, 13'h02A9);
    for (int i = 0; i < 3; i++) begin
      chk("busy_phase", bus.busy, 1);
      chk("busy_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    chk("done_out_valid", bus.out_valid, 1);
    chk("done_result", bus.result, 13'h02A9);
    @(posedge clk); #1;
    chk("back_idle_in_ready", bus.in_ready, 1);
    chk("back_idle_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      send(vs[i], vc[i], ve[i]);
      wait_idle();
    end
    // backpressure: DONE held while inputs churn
    bus.out_ready = 1'b0;
    send(11'h400, 11'h400, 13'h0C00);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = bus.out_valid;
    end
    if (!ok) flag("stall_valid", "got out_valid low for 20 cycles, required high");
    for (int i = 0; i < 10; i++) begin
      bus.sum = W'($urandom);
      bus.carry = W'($urandom);
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("stall_result", bus.result, 13'h0C00);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_pending", q.size(), 0);
    // abort in the second BUSY cycle
    send(11'h155, 11'h0AA, 13'h02A9);
    @(posedge clk); #2;
    chk("pre_abort_busy", bus.busy, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(11'h001, 11'h001, 13'h0003);
    wait_idle();
    rand_go = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      ok = rg[0].fin && rg[1].fin && rg[2].fin && rg[3].fin;
    end
    if (!ok) flag("random_done", "got unfinished random runs after 20000 cycles, required all finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
